gol_grid_engine: RTL

//   Parametrised Game-of-Life core: WIDTHxHEIGHT cell grid held in flops, next

---
 rtl/gol_grid_engine_if.sv | 24 ++
 rtl/gol_grid_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/gol_grid_engine_if.sv
// Load and readback port bundle for the Game-of-Life grid engine.
// The master side writes rows and selects a readback row; the engine is the slave.
interface gol_grid_engine_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
);
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [RW-1:0]    rd_row;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output load_valid, load_data, rd_row,
        input  load_ready, rd_data
    );

    modport slave (
        input  load_valid, load_data, rd_row,
        output load_ready, rd_data
    );
endinterface

// File: rtl/gol_grid_engine.sv
// Game-of-Life core: whole grid held in flops, one generation per cycle when fired.
// Rows are loaded over a valid/ready port and read back one registered row at a time.
module gol_grid_engine #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter bit          WRAP   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    gol_grid_engine_if.slave    bus,
    input  logic                step,
    input  logic                run,
    input  logic [15:0]         period,
    output logic [CNT_W-1:0]    gen_count,
    output logic                busy,
    output logic                stable,
    output logic                extinct
);
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned NC = WIDTH * HEIGHT;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [NC-1:0]     grid_q, grid_d;
    logic [RW-1:0]     load_ptr_q, load_ptr_d;
    logic [15:0]       timer_q, timer_d;
    logic [CNT_W-1:0]  gen_count_q, gen_count_d;
    logic              stable_q, stable_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [NC-1:0]     next_grid;
    logic              gen_fire;

    // Cell (r,c) lives at bit r*WIDTH+c; off-grid neighbours wrap or read as dead.
    always_comb begin : next_gen
        int       rr;
        int       cc;
        logic [3:0] nbr;
        next_grid = '0;
        for (int r = 0; r < int'(HEIGHT); r++) begin
            for (int c = 0; c < int'(WIDTH); c++) begin
                nbr = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (WRAP) begin
                                rr = (rr + int'(HEIGHT)) % int'(HEIGHT);
                                cc = (cc + int'(WIDTH)) % int'(WIDTH);
                            end
                            if (rr >= 0 && rr < int'(HEIGHT) && cc >= 0 && cc < int'(WIDTH)) begin
                                nbr = nbr + {3'b000, grid_q[rr * int'(WIDTH) + cc]};
                            end
                        end
                    end
                end
                next_grid[r * int'(WIDTH) + c] = (nbr == 4'd3) ||
                                                 (grid_q[r * int'(WIDTH) + c] && nbr == 4'd2);
            end
        end
    end

    always_comb begin : control
        state_d     = state_q;
        grid_d      = grid_q;
        load_ptr_d  = load_ptr_q;
        timer_d     = timer_q;
        gen_count_d = gen_count_q;
        stable_d    = stable_q;
        gen_fire    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    grid_d[int'(load_ptr_q) * int'(WIDTH) +: WIDTH] = bus.load_data;
                    load_ptr_d  = (load_ptr_q == RW'(HEIGHT - 1)) ? '0 : load_ptr_q + 1'b1;
                    gen_count_d = '0;
                    stable_d    = 1'b0;
                    timer_d     = '0;
                end else if (run) begin
                    state_d = StRun;
                    timer_d = '0;
                end else if (step) begin
                    gen_fire = 1'b1;
                end
            end
            StRun: begin
                if (!run) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q == period) begin
                    gen_fire = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (gen_fire) begin
            grid_d   = next_grid;
            stable_d = (next_grid == grid_q);
            if (gen_count_q != '1) begin
                gen_count_d = gen_count_q + CNT_W'(1);
            end
        end

        // Readback samples the pre-update grid on a generation edge.
        rd_data_d = '0;
        if (int'(bus.rd_row) < int'(HEIGHT)) begin
            rd_data_d = grid_q[int'(bus.rd_row) * int'(WIDTH) +: WIDTH];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            grid_q      <= '0;
            load_ptr_q  <= '0;
            timer_q     <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            load_ptr_q  <= load_ptr_d;
            timer_q     <= timer_d;
            gen_count_q <= gen_count_d;
            stable_q    <= stable_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.load_ready = (state_q == StIdle);
    assign bus.rd_data    = rd_data_q;
    assign busy           = (state_q == StRun);
    assign gen_count      = gen_count_q;
    assign stable         = stable_q;
    assign extinct        = (grid_q == '0);
endmodule
